imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 117 +++++++++++
 tb/tb_imem_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Streams a length-prefixed big-endian program image into instruction memory,
// holding the CPU until every word has been written.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [31:0] word;

    logic        accept_c;
    logic [15:0] len_lo_c;
    logic [15:0] idx_inc_c;
    logic [31:0] word_shift_c;

    assign accept_c     = byte_valid && byte_ready;
    assign len_lo_c     = {len[15:8], byte_data};
    assign idx_inc_c    = word_idx + 16'd1;
    assign word_shift_c = {word[23:0], byte_data};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LEN_HI;
            LEN_HI:          if (accept_c) state_nxt = LEN_LO;
            LEN_LO: begin
                if (accept_c) begin
                    if (len_lo_c == 16'd0)                state_nxt = DONE;
                    else if (32'(len_lo_c) > DEPTH_WORDS) state_nxt = ERR;
                    else                                  state_nxt = DATA;
                end
            end
            DATA:    if (accept_c && byte_idx == 2'd3) state_nxt = WRITE;
            WRITE:   state_nxt = (idx_inc_c == len) ? DONE : DATA;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            len        <= 16'd0;
            word_idx   <= 16'd0;
            byte_idx   <= 2'd0;
            word       <= 32'd0;
        end else begin
            byte_ready <= (state_nxt == LEN_HI) || (state_nxt == LEN_LO) || (state_nxt == DATA);
            imem_we    <= (state_nxt == WRITE);
            cpu_hold   <= (state_nxt != DONE);
            done       <= (state_nxt == DONE);
            error      <= (state_nxt == ERR);

            if (accept_c) begin
                case (state)
                    LEN_HI: len[15:8] <= byte_data;
                    LEN_LO: begin
                        len[7:0] <= byte_data;
                        word_idx <= 16'd0;
                        byte_idx <= 2'd0;
                    end
                    DATA: begin
                        word     <= word_shift_c;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_wdata <= word_shift_c;
                            imem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                        end
                    end
                    default: ;
                endcase
            end

            if (state == WRITE) word_idx <= idx_inc_c;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized sessions for imem_loader, checked against a byte-stream model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    localparam int unsigned DEPTH = 256;

    int vectors    = 0;
    int miscompares = 0;
    int ready_viol = 0;

    logic [7:0]  stream[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    // Record every memory write; byte_ready must be low whenever a write is issued
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            obs_addr.push_back(imem_addr);
            obs_data.push_back(imem_wdata);
            if (byte_ready) ready_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic make_stream(input int n);
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    endtask

    // Expected writes: every word whose last byte lies within the first 'upto' stream bytes
    task automatic model_words(input int upto);
        int n;
        exp_addr.delete();
        exp_data.delete();
        obs_addr.delete();
        obs_data.delete();
        ready_viol = 0;
        n = (int'(stream[0]) << 8) | int'(stream[1]);
        if (n > int'(DEPTH)) return;
        for (int i = 0; i < n; i++) begin
            if (6 + 4 * i <= upto) begin
                exp_addr.push_back(32'(4 * i));
                exp_data.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
            end
        end
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < obs_addr.size()) begin
                check({tag, "_addr"}, obs_addr[i], exp_addr[i]);
                check({tag, "_data"}, obs_data[i], exp_data[i]);
            end
        end
        check({tag, "_ready_in_write"}, 32'(ready_viol), 32'd0);
    endtask

    task automatic do_start(input string tag);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_start_hold"},  32'(cpu_hold),   32'd1);
        check({tag, "_start_done"},  32'(done),       32'd0);
        check({tag, "_start_err"},   32'(error),      32'd0);
        check({tag, "_start_ready"}, 32'(byte_ready), 32'd1);
    endtask

    // mode 0: valid always; 1: toggle every cycle; 2: random. start pulsed with byte start_at.
    task automatic send_stream(input int mode, input int start_at, input int count);
        int p   = 0;
        int cyc = 0;
        bit ph  = 1'b1;
        while (p < count) begin
            @(posedge clk); #1;
            case (mode)
                0:       byte_valid = 1'b1;
                1:       byte_valid = ph;
                default: byte_valid = ($urandom_range(0, 99) < 60);
            endcase
            ph = !ph;
            byte_data = byte_valid ? stream[p] : 8'($urandom);
            start     = (p == start_at) && byte_valid;
            @(negedge clk);
            if (byte_valid && byte_ready) p++;
            cyc++;
            if (cyc > 4000) begin
                check("stream_timeout", 32'(p), 32'(count));
                break;
            end
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic run_session(input string tag, input int mode, input int start_at);
        int n;
        n = (int'(stream[0]) << 8) | int'(stream[1]);
        model_words(stream.size());
        do_start(tag);
        send_stream(mode, start_at, stream.size());
        @(negedge clk);
        if (n == 0) begin
            check({tag, "_done"}, 32'(done),     32'd1);
            check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
            check({tag, "_we"},   32'(imem_we),  32'd0);
        end else if (n > int'(DEPTH)) begin
            check({tag, "_error"}, 32'(error),      32'd1);
            check({tag, "_hold"},  32'(cpu_hold),   32'd1);
            check({tag, "_ready"}, 32'(byte_ready), 32'd0);
            check({tag, "_we"},    32'(imem_we),    32'd0);
        end else begin
            check({tag, "_we_latency"}, 32'(imem_we), 32'd1);
            @(negedge clk);
            check({tag, "_done"}, 32'(done),     32'd1);
            check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        end
        repeat (3) @(negedge clk);
        compare_writes(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_we"},    32'(imem_we),    32'd0);
        check({tag, "_addr"},  imem_addr,       32'd0);
        check({tag, "_wdata"}, imem_wdata,      32'd0);
        check({tag, "_hold"},  32'(cpu_hold),   32'd1);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_err"},   32'(error),      32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        #25;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle must ignore bytes until start
        @(posedge clk); #1;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(byte_ready), 32'd0);
        check("idle_hold",  32'(cpu_hold),   32'd1);
        byte_valid = 1'b0;

        // Two-word directed image
        stream.delete();
        stream = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        run_session("two_words", 0, -1);

        // Empty image
        stream.delete();
        stream = '{8'h00, 8'h00};
        run_session("empty", 0, -1);

        // Oversized header, then a later start must clear error
        stream.delete();
        stream = '{8'h01, 8'h01};
        run_session("oversize", 0, -1);

        // Single word with byte_valid toggling
        make_stream(1);
        run_session("toggle", 1, -1);

        // Start pulsed mid-data is ignored
        make_stream(3);
        run_session("start_mid", 0, 5);

        // Reset after 6 of 12 data bytes
        make_stream(3);
        model_words(7);
        do_start("rst_mid");
        send_stream(0, -1, 8);
        #1 rst_n = 1'b0;
        #1 check_reset_values("rst_mid_async");
        repeat (3) @(negedge clk);
        compare_writes("rst_mid");
        rst_n = 1'b1;
        make_stream(3);
        run_session("after_rst", 2, -1);

        // Capacity boundary
        make_stream(int'(DEPTH));
        run_session("full_depth", 0, -1);

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            make_stream(int'($urandom_range(1, 8)));
            run_session("random", 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
